// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap feed path: word widths, row tag bit
// positions and the frame FSM state type.
package ifmap_pkg;

  localparam int IF_DATA_WIDTH = 16;
  localparam int TAG_SOR       = IF_DATA_WIDTH + 1;
  localparam int TAG_EOR       = IF_DATA_WIDTH;

  // Frame sequencing; shared with the outbuf drainer side.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } feed_state_e;

endpackage

// File: rtl/ifmap_row_tagger_if.sv
// Raw ifmap stream in, tagged IF buffer write port out.
interface ifmap_row_tagger_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  IF_full;
  logic                  IF_wen;
  logic [DATA_WIDTH+1:0] IF_din;

  // Host/DMA and IF buffer side.
  modport master (
    output in_valid, in_data, IF_full,
    input  in_ready, IF_wen, IF_din
  );

  // Tagger side.
  modport slave (
    input  in_valid, in_data, IF_full,
    output in_ready, IF_wen, IF_din
  );
endinterface

// File: rtl/if_skid_fifo.sv
// Two-entry register FIFO; slot0 is always the head.
module if_skid_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;

  assign dout_o  = slot0_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

  // Next occupancy/contents; pop shifts slot1 forward, push fills the first free slot.
  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = din_i;
        else               slot1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = din_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers; reset discards queued words and zeroes the head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/ifmap_row_tagger.sv
// Counts raw ifmap words into rows, tags start/end of row and feeds the
// IF buffer through a 2-entry skid queue that absorbs IF_full.
module ifmap_row_tagger
  import ifmap_pkg::*;
#(
  parameter int DATA_WIDTH = IF_DATA_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] row_len,
  input  logic [LEN_WIDTH-1:0] num_rows,
  output logic                 busy,
  output logic                 done,
  output logic                 err_cfg,
  ifmap_row_tagger_if.slave    bus
);

  feed_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0] row_len_q, row_len_d;
  logic [LEN_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [LEN_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [LEN_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic                 err_cfg_q, err_cfg_d;

  logic                  skid_full, skid_empty;
  logic                  in_ready_w, push, pop;
  logic                  sor, eor, last_row, cfg_ok;
  logic [DATA_WIDTH+1:0] head;

  assign cfg_ok   = (row_len != '0) && (num_rows != '0);
  assign sor      = (col_cnt_q == '0);
  assign eor      = (col_cnt_q == row_len_q - LEN_WIDTH'(1));
  assign last_row = (row_cnt_q == num_rows_q - LEN_WIDTH'(1));

  // in_ready depends only on registered state, so IF_full reaches it one cycle late.
  assign in_ready_w = (state_q == ST_STREAM) && !skid_full;
  assign push       = bus.in_valid && in_ready_w;
  assign pop        = !skid_empty && !bus.IF_full;

  assign bus.in_ready = in_ready_w;
  assign bus.IF_wen   = pop;
  assign bus.IF_din   = head;
  assign busy         = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign err_cfg      = err_cfg_q;

  if_skid_fifo #(.WIDTH(DATA_WIDTH + 2)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({sor, eor, bus.in_data}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  // Frame FSM next state, config latch and row/column counting.
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_rows_d = num_rows_q;
    col_cnt_d  = col_cnt_q;
    row_cnt_d  = row_cnt_q;
    err_cfg_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            row_len_d  = row_len;
            num_rows_d = num_rows;
            col_cnt_d  = '0;
            row_cnt_d  = '0;
            state_d    = ST_STREAM;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (push) begin
          if (eor) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + LEN_WIDTH'(1);
            if (last_row) state_d = ST_DRAIN;
          end else begin
            col_cnt_d = col_cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: if (skid_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      err_cfg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_rows_q <= num_rows_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      err_cfg_q  <= err_cfg_d;
    end
  end

endmodule

// File: tb/tb_ifmap_row_tagger.sv
// Directed bench for ifmap_row_tagger: frames, row wrap, back-pressure,
// degenerate configs and reset mid-frame.
module tb_ifmap_row_tagger;
  import ifmap_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] row_len, num_rows;
  logic       busy, done, err_cfg;

  ifmap_row_tagger_if #(.DATA_WIDTH(16)) bus ();

  ifmap_row_tagger #(.DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row_len  (row_len),
    .num_rows (num_rows),
    .busy     (busy),
    .done     (done),
    .err_cfg  (err_cfg),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [17:0] got_q[$];
  int          wcyc_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          wr_full  = 0;

  logic [15:0] tx_q[$];
  logic [17:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.IF_wen) begin
      got_q.push_back(bus.IF_din);
      wcyc_q.push_back(cyc);
    end
    if (bus.IF_wen && bus.IF_full) wr_full++;
    if (done) done_cnt++;
    if (err_cfg) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic do_start(input logic [7:0] len, input logic [7:0] rows);
    start = 1'b1; row_len = len; num_rows = rows;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_all();
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < tx_q.size() && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tx_q[i];
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("send_count", i, tx_q.size());
  endtask

  task automatic wait_done(input string tag, input int d0);
    int guard = 0;
    while (done_cnt == d0 && guard < 100) begin
      @(negedge clk); guard++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic check_writes(input string tag, input int base);
    chk({tag, "_nwr"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) chk(tag, 32'(got_q[base + i]), 32'(exp_q[i]));
  endtask

  initial begin
    int   base, d0, e0;
    logic rdy_last;

    rst = 1'b0; start = 1'b0; row_len = '0; num_rows = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.IF_full = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_IF_wen",   bus.IF_wen,   0);
    chk("rst_IF_din",   bus.IF_din,   0);
    chk("rst_busy",     busy,         0);
    chk("rst_done",     done,         0);
    chk("rst_err_cfg",  err_cfg,      0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic frame with signed data and consecutive writes
    base = got_q.size(); d0 = done_cnt;
    tx_q  = '{16'd1, 16'hFFE5, 16'd0, 16'd3};
    exp_q = '{18'h20001, 18'h0FFE5, 18'h00000, 18'h10003};
    do_start(8'd4, 8'd1);
    chk("t1_busy", busy, 1);
    send_all();
    wait_done("t1_done", d0);
    check_writes("t1_word", base);
    for (int i = 1; i < 4; i++)
      if (base + i < wcyc_q.size()) chk("t1_tput", wcyc_q[base + i] - wcyc_q[base + i - 1], 1);
    chk("t1_busy_end", busy, 0);

    // Row wrap: SOR/EOR alternate for six words
    base = got_q.size(); d0 = done_cnt;
    tx_q = '{}; exp_q = '{};
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(16'(i + 1));
      exp_q.push_back({(i % 2 == 0), (i % 2 == 1), 16'(i + 1)});
    end
    do_start(8'd2, 8'd3);
    send_all();
    wait_done("t2_done", d0);
    check_writes("t2_word", base);

    // Back-pressure: IF_full for five cycles mid-frame
    base = got_q.size(); d0 = done_cnt; e0 = wr_full;
    tx_q = '{}; exp_q = '{};
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(16'h0100 + 16'(i));
      exp_q.push_back({(i % 4 == 0), (i % 4 == 3), 16'h0100 + 16'(i)});
    end
    do_start(8'd4, 8'd2);
    rdy_last = 1'b1;
    fork
      send_all();
      begin
        repeat (3) @(posedge clk);
        #1 bus.IF_full = 1'b1;
        repeat (5) begin
          @(negedge clk); rdy_last = bus.in_ready;
        end
        @(posedge clk); #1;
        bus.IF_full = 1'b0;
      end
    join
    chk("t3_ready_low", rdy_last, 0);
    wait_done("t3_done", d0);
    chk("t3_wr_full", wr_full - e0, 0);
    check_writes("t3_word", base);

    // row_len=1: both tags on every word
    base = got_q.size(); d0 = done_cnt;
    tx_q  = '{16'd7, 16'hFFFF};
    exp_q = '{18'h30007, 18'h3FFFF};
    do_start(8'd1, 8'd2);
    send_all();
    wait_done("t4_done", d0);
    check_writes("t4_word", base);
    chk("t4_sor_pos", got_q[base][TAG_SOR], 1);

    // Zero lengths: error pulse, no frame
    e0 = err_cnt;
    do_start(8'd0, 8'd3);
    @(negedge clk);
    chk("t5_err_pulse", err_cfg, 1);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_err_clear", err_cfg, 0);
    chk("t5_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    do_start(8'd2, 8'd0);
    repeat (3) @(negedge clk);
    chk("t5_err_cnt", err_cnt - e0, 2);
    chk("t5_busy2", busy, 0);
    @(posedge clk); #1;

    // Reset mid-frame: queued word is dropped
    tx_q = '{16'hA001, 16'hA002, 16'hA003};
    do_start(8'd8, 8'd1);
    send_all();
    bus.IF_full = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.IF_full = 1'b0;
    @(negedge clk);
    chk("t6_IF_wen",   bus.IF_wen,   0);
    chk("t6_IF_din",   bus.IF_din,   0);
    chk("t6_in_ready", bus.in_ready, 0);
    chk("t6_busy",     busy,         0);
    chk("t6_done",     done,         0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    base = got_q.size(); d0 = done_cnt;
    tx_q = '{}; exp_q = '{};
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(16'hB000 + 16'(i));
      exp_q.push_back({(i == 0), (i == 7), 16'hB000 + 16'(i)});
    end
    do_start(8'd8, 8'd1);
    send_all();
    wait_done("t6_done_rerun", d0);
    check_writes("t6_word", base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
